// File: rtl/la_stdlib_pkg.sv
// Shared constant helpers for the stdlib reduction cells: 4-ary tree depth,
// pipeline stage count and per-level operand widths.
package la_stdlib_pkg;

   // Smallest k with 4**k >= n (clog4(1) = 0).
   function automatic int clog4(input int n);
      int k;
      longint p;
      k = 0;
      p = 1;
      for (int i = 0; i < 32; i++) begin
         if (p < longint'(n)) begin
            p = p * 4;
            k++;
         end
      end
      return k;
   endfunction

   // Tree depth; a single input still gets one level so N = 1 is a buffer.
   function automatic int tree_levels(input int n);
      return (clog4(n) < 1) ? 1 : clog4(n);
   endfunction

   // Number of register stages when REG_EVERY levels share one stage.
   function automatic int pipe_stages(input int n, input int reg_every);
      return (tree_levels(n) + reg_every - 1) / reg_every;
   endfunction

   // Operand width per channel after lv 4-input levels.
   function automatic int level_width(input int n, input int lv);
      int w;
      w = n;
      for (int i = 0; i < lv; i++) w = (w + 3) / 4;
      return w;
   endfunction

   // Tree levels handled by stage k (the last stage may get fewer).
   function automatic int stage_levels(input int n, input int reg_every, input int k);
      int rem;
      rem = tree_levels(n) - k * reg_every;
      return (rem < reg_every) ? rem : reg_every;
   endfunction

endpackage

// File: rtl/la_andn_stage.sv
// One pipeline stage of the AND tree: LEVELS levels of 4-input AND per channel
// (missing leaves read as 1), then a data register and valid bit that load
// when the stage is empty or its contents leave this cycle.
module la_andn_stage #(
   parameter int WIN    = 16,
   parameter int WOUT   = 4,
   parameter int LEVELS = 1,
   parameter int CH     = 1,
   parameter bit INV    = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CH*WIN-1:0]   in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CH*WOUT-1:0]  out_data
);

   logic [CH*WOUT-1:0] reduced;
   logic               valid;
   logic [CH*WOUT-1:0] data;

   // Bits above the live width stay 1 from level to level, which is the padding.
   function automatic logic [WOUT-1:0] and4_tree(input logic [WIN-1:0] v);
      logic [WIN-1:0] cur;
      logic [WIN-1:0] nxt;
      logic           b;
      cur = v;
      for (int l = 0; l < LEVELS; l++) begin
         nxt = '1;
         for (int i = 0; i < WIN; i++) begin
            b = 1'b1;
            for (int j = 0; j < 4; j++)
               if (4 * i + j < WIN) b = b & cur[4*i+j];
            nxt[i] = b;
         end
         cur = nxt;
      end
      return cur[WOUT-1:0];
   endfunction

   // Per-channel reduction; inversion sits ahead of the register so z stays registered.
   always_comb begin
      reduced = '0;
      for (int c = 0; c < CH; c++)
         reduced[c*WOUT +: WOUT] = and4_tree(in_data[c*WIN +: WIN]) ^ {WOUT{INV}};
   end

   assign in_ready  = !valid || out_ready;
   assign out_valid = valid;
   assign out_data  = data;

   // Stage register: valid follows the upstream beat when loading, data only on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         if (in_ready) valid <= in_valid;
         if (in_valid && in_ready) data <= reduced;
      end
   end

endmodule

// File: rtl/la_andn_pipe.sv
// Pipelined N-input AND (or NAND) reduction over CH channels sharing one
// valid/ready stream. Stages are chained through a full-width bus so each
// stage can take whatever width the previous one leaves behind.
module la_andn_pipe
   import la_stdlib_pkg::*;
#(
   parameter int N         = 16,
   parameter int CH        = 1,
   parameter int REG_EVERY = 1,
   parameter int INVERT    = 0,
   parameter     PROP      = "DEFAULT"
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CH*N-1:0] in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [CH-1:0]   z
);

   localparam int S = pipe_stages(N, REG_EVERY);
   localparam int W = CH * N;

   logic [S:0][W-1:0] bus;
   logic [S:0]        vld;
   logic [S:0]        rdy;
   logic              unused_bus;

   assign bus[0]     = in;
   assign vld[0]     = in_valid;
   assign rdy[S]     = out_ready;
   assign in_ready   = rdy[0];
   assign out_valid  = vld[S];
   assign z          = bus[S][CH-1:0];
   // Upper bus bits past each stage's width carry zeros and are never read.
   assign unused_bus = ^bus;

   for (genvar k = 0; k < S; k++) begin : g_stage
      localparam int LV = stage_levels(N, REG_EVERY, k);
      localparam int WI = level_width(N, k * REG_EVERY);
      localparam int WO = level_width(N, k * REG_EVERY + LV);
      localparam bit IV = (k == S - 1) && (INVERT != 0);

      logic [CH*WO-1:0] sdata;

      la_andn_stage #(
         .WIN   (WI),
         .WOUT  (WO),
         .LEVELS(LV),
         .CH    (CH),
         .INV   (IV)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .in_valid (vld[k]),
         .in_ready (rdy[k]),
         .in_data  (bus[k][CH*WI-1:0]),
         .out_valid(vld[k+1]),
         .out_ready(rdy[k+1]),
         .out_data (sdata)
      );

      assign bus[k+1] = W'(sdata);
   end

endmodule

// File: tb/tb_la_andn_pipe.sv
// Bench for la_andn_pipe: five configurations exercised from one clock.
module tb_la_andn_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // A: N=16 CH=2 REG_EVERY=1 (S=2)
   logic a_iv = 0, a_ir, a_ov, a_or = 1;
   logic [31:0] a_in = '0;
   logic [1:0]  a_z;
   // B: N=5 CH=1 (S=2)
   logic b_iv = 0, b_ir, b_ov, b_or = 1;
   logic [4:0] b_in = '0;
   logic [0:0] b_z;
   // C: N=64 CH=3 INVERT REG_EVERY=2 (S=2); D: same with REG_EVERY=3 (S=1)
   logic c_iv = 0, c_ir, c_ov, c_or = 1, d_ir, d_ov;
   logic [191:0] c_in = '0;
   logic [2:0] c_z, d_z;
   // E: N=37 CH=4 random handshake
   logic e_iv = 0, e_ir, e_ov, e_or = 1;
   logic [147:0] e_in = '0;
   logic [3:0] e_z;

   la_andn_pipe #(.N(16), .CH(2), .REG_EVERY(1), .INVERT(0)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in(a_in),
      .out_valid(a_ov), .out_ready(a_or), .z(a_z));
   la_andn_pipe #(.N(5), .CH(1), .REG_EVERY(1), .INVERT(0)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in(b_in),
      .out_valid(b_ov), .out_ready(b_or), .z(b_z));
   la_andn_pipe #(.N(64), .CH(3), .REG_EVERY(2), .INVERT(1)) u_c (
      .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in(c_in),
      .out_valid(c_ov), .out_ready(c_or), .z(c_z));
   la_andn_pipe #(.N(64), .CH(3), .REG_EVERY(3), .INVERT(1)) u_d (
      .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(d_ir), .in(c_in),
      .out_valid(d_ov), .out_ready(c_or), .z(d_z));
   la_andn_pipe #(.N(37), .CH(4), .REG_EVERY(1), .INVERT(0)) u_e (
      .clk(clk), .rst(rst), .in_valid(e_iv), .in_ready(e_ir), .in(e_in),
      .out_valid(e_ov), .out_ready(e_or), .z(e_z));

   typedef struct { logic [4:0] in; logic z; } vec_b_t;
   typedef struct { logic [191:0] in; logic [2:0] z; } vec_c_t;

   vec_b_t     tb_b[$];
   vec_c_t     tb_c[$];
   logic       qb[$];
   logic [2:0] qc[$];
   logic [2:0] qd[$];
   logic [3:0] qe[$];

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] nand64x3(input logic [191:0] v);
      logic [2:0] r;
      for (int c = 0; c < 3; c++) r[c] = ~&v[c*64 +: 64];
      return r;
   endfunction

   function automatic logic [3:0] and37x4(input logic [147:0] v);
      logic [3:0] r;
      for (int c = 0; c < 4; c++) r[c] = &v[c*37 +: 37];
      return r;
   endfunction

   function automatic logic [36:0] rand_ch37();
      logic [36:0] v;
      int m;
      m = $urandom_range(0, 3);
      v = '1;
      if (m == 1) v[$urandom_range(0, 36)] = 1'b0;
      else if (m == 2) v = {5'($urandom), 32'($urandom)};
      return v;
   endfunction

   initial begin
      logic [191:0] one;
      logic [191:0] rv;
      int i, cyc, got, sent;
      logic held_v;
      logic [3:0] held_z;

      // ---------------- reset ----------------
      #2;
      chk("rst_a_ov", a_ov, 0);
      chk("rst_a_z", a_z, 0);
      chk("rst_a_ir", a_ir, 1);
      chk("rst_c_z_inv", c_z, 0);
      step();
      step();
      rst = 0;
      a_or = 0;
      a_iv = 1;
      a_in = '1;
      step();
      step();
      #3 rst = 1;
      #1;
      chk("rst_mid_a_ov", a_ov, 0);
      chk("rst_mid_a_z", a_z, 0);
      chk("rst_mid_a_ir", a_ir, 1);
      a_iv = 0;
      step();
      rst = 0;
      a_or = 1;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("rst_no_stale", a_ov, 0);
      end

      // ---------------- A: latency and streaming ----------------
      a_in = 32'hFFFF_FFFF;
      a_iv = 1;
      #1 chk("a_ir_stream", a_ir, 1);
      step();
      chk("a_lat_early", a_ov, 0);
      a_in = 32'hFFFF_FFFE;
      step();
      chk("a_stream0", {a_ov, a_z}, 3'b111);
      a_in = 32'h7FFF_FFFF;
      step();
      chk("a_stream1", {a_ov, a_z}, 3'b110);
      a_iv = 0;
      step();
      chk("a_stream2", {a_ov, a_z}, 3'b101);
      step();
      chk("a_stream_end", a_ov, 0);

      // ---------------- A: backpressure ----------------
      a_or = 0;
      a_iv = 1;
      a_in = 32'hFFFF_FFFF;
      step();
      a_in = 32'h0000_FFFF;
      #1 chk("a_bp_ir2", a_ir, 1);
      step();
      a_in = 32'hFFFF_0000;
      #1 chk("a_bp_full", a_ir, 0);
      chk("a_bp_head", {a_ov, a_z}, 3'b111);
      step();
      chk("a_bp_hold1", {a_ov, a_z}, 3'b111);
      step();
      chk("a_bp_hold2", {a_ov, a_z}, 3'b111);
      a_or = 1;
      #1 chk("a_pushpop_ir", a_ir, 1);
      step();
      chk("a_drain1", {a_ov, a_z}, 3'b101);
      a_iv = 0;
      step();
      chk("a_drain2", {a_ov, a_z}, 3'b110);
      step();
      chk("a_drain_end", a_ov, 0);

      // ---------------- B: padding, exhaustive N=5 ----------------
      tb_b.push_back('{5'b11111, 1'b1});
      tb_b.push_back('{5'b10111, 1'b0});
      for (int v = 0; v < 32; v++) begin
         logic [4:0] vv;
         vv = 5'(v);
         tb_b.push_back('{vv, &vv});
      end
      i = 0;
      cyc = 0;
      while ((i < tb_b.size() || qb.size() > 0) && cyc < 500) begin
         b_iv = (i < tb_b.size());
         if (b_iv) b_in = tb_b[i].in;
         #1;
         if (b_ov && b_or) begin
            if (qb.size() == 0) chk("b_extra", 1, 0);
            else chk("b_data", b_z, qb.pop_front());
         end
         if (b_iv && b_ir) begin
            qb.push_back(tb_b[i].z);
            i++;
         end
         step();
         cyc++;
      end
      b_iv = 0;
      chk("b_done", i, tb_b.size());

      // ---------------- C/D: INVERT, REG_EVERY sweep ----------------
      one = 192'd1;
      c_iv = 1;
      c_in = '1;
      step();
      chk("c_lat1", c_ov, 0);
      chk("d_lat1", {d_ov, d_z}, 4'b1000);
      c_in = ~(one << 64);
      step();
      chk("c_lat2", {c_ov, c_z}, 4'b1000);
      chk("d_ch1", {d_ov, d_z}, 4'b1010);
      c_iv = 0;
      step();
      chk("c_ch1", {c_ov, c_z}, 4'b1010);
      chk("d_empty", d_ov, 0);
      step();
      chk("c_empty", c_ov, 0);

      tb_c.push_back('{192'd0, 3'b111});
      tb_c.push_back('{~192'd0, 3'b000});
      tb_c.push_back('{~one, 3'b001});
      tb_c.push_back('{~(one << 191), 3'b100});
      tb_c.push_back('{~(one << 64), 3'b010});
      for (int k = 0; k < 8; k++) begin
         rv = '1;
         for (int c = 0; c < 3; c++)
            if ($urandom_range(0, 1) == 1) rv[c*64 + $urandom_range(0, 63)] = 1'b0;
         tb_c.push_back('{rv, nand64x3(rv)});
      end
      i = 0;
      cyc = 0;
      while ((i < tb_c.size() || qc.size() > 0 || qd.size() > 0) && cyc < 500) begin
         c_iv = (i < tb_c.size());
         if (c_iv) c_in = tb_c[i].in;
         #1;
         if (c_ov) begin
            if (qc.size() == 0) chk("c_extra", 1, 0);
            else chk("c_data", c_z, qc.pop_front());
         end
         if (d_ov) begin
            if (qd.size() == 0) chk("d_extra", 1, 0);
            else chk("d_data", d_z, qd.pop_front());
         end
         if (c_iv && c_ir && d_ir) begin
            qc.push_back(tb_c[i].z);
            qd.push_back(tb_c[i].z);
            i++;
         end
         step();
         cyc++;
      end
      c_iv = 0;
      chk("cd_done", i, tb_c.size());

      // ---------------- E: random handshake scoreboard ----------------
      got = 0;
      sent = 0;
      cyc = 0;
      held_v = 0;
      held_z = '0;
      while (got < 10000 && cyc < 60000) begin
         if (held_v) chk("e_stall_stable", {e_ov, e_z}, {1'b1, held_z});
         e_iv = ($urandom_range(0, 1) == 1) && (sent < 10000);
         if (e_iv)
            for (int c = 0; c < 4; c++) e_in[c*37 +: 37] = rand_ch37();
         e_or = ($urandom_range(0, 1) == 1);
         #1;
         held_v = e_ov && !e_or;
         held_z = e_z;
         if (e_ov && e_or) begin
            if (qe.size() == 0) chk("e_extra", 1, 0);
            else chk("e_data", e_z, qe.pop_front());
            got++;
         end
         if (e_iv && e_ir) begin
            qe.push_back(and37x4(e_in));
            sent++;
         end
         step();
         cyc++;
      end
      e_iv = 0;
      chk("e_beats", got, 10000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/la_andn_pipe.md
Name: la_andn_pipe

Overview:
Parametrised, pipelined N-input AND reduction for wide operands. Supports CH independent channels that share one valid/ready stream. The combinational core is a tree of 4-input AND levels, with a register stage after every REG_EVERY levels, so it can close timing on very wide reductions. It sits in the stdlib alongside the fixed-width AND cells, for use in wide match/compare and all-done detection paths.

Parameters:
N, 16, inputs per channel (N >= 1)
CH, 1, number of independent channels (CH >= 1)
REG_EVERY, 1, 4-input tree levels per pipeline stage (REG_EVERY >= 1)
INVERT, 0, 1 = each channel output is NAND instead of AND
PROP, "DEFAULT", technology/implementation property string, passed through unchanged

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block accepts beat this cycle
in  input  CH*N  operand; channel c occupies bits [c*N +: N]
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
z  output  CH  z[c] = AND (or NAND) of channel c's N bits

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high on rst.
- Tree depth: L = max(1, ceil(log4 N)) levels.
- Pipeline depth: S = ceil(L / REG_EVERY) stages. The last stage register drives z and out_valid directly.
- Padding: unused leaf inputs, where N is not a power of 4, are tied to 1. Padding never affects the result.
- Inversion: INVERT is applied before the final register, so z is always a registered output.
- Latency: an accepted beat (in_valid & in_ready) appears on z/out_valid exactly S cycles later when out_ready is held high.
- Throughput: one beat per cycle with out_ready high.
- Stage k state: valid_k and data_k. Stage k loads when it is empty or its contents move on this cycle:
  - ready_k = !valid_k | ready_{k+1}
  - ready_S = out_ready
  - in_ready = ready_0 (purely combinational from the valid bits and out_ready)
- Bubbles: an empty stage always accepts, so bubbles collapse.
- Backpressure: with out_ready low, the pipeline fills. in_ready falls once all S stages are valid. Held data is stable; z must not change while out_valid & !out_ready.
- Data isolation: data_k updates only on load. A beat that is not accepted (in_valid low or in_ready low) never alters state.
- Simultaneous pop and push on a full pipeline: both occur in the same cycle with no bubble.
- Reset:
  - All valid_k = 0; all data_k = 0.
  - Outputs: out_valid = 0, z = 0 (for INVERT too), in_ready = 1 one delta after reset asserts.
  - Reset mid-operation drops all in-flight beats. No output of a pre-reset beat may appear after rst deasserts.
- No combinational path from in to z. The only combinational paths are out_ready -> in_ready.
- N = 1 degenerates to L = 1, S = 1: a registered buffer (or inverter) with handshake.

Decomposition:
- Shared package/include la_stdlib_pkg:
  - clog4 constant function
  - derived-constant helpers for L and S
- Sub-module la_andn_stage (per pipeline stage, instantiated S times via generate):
  - parameters WIN, WOUT, LEVELS, CH, INV
  - contents: combinational 4-ary AND of up to LEVELS levels with 1-padding, plus CH*WOUT data register and valid bit with the ready_k rule
- INV is set only on the last stage.

Test Plan:
- Reset check (N=16, CH=2, REG_EVERY=1, S=2): assert rst with traffic in flight -> out_valid=0, z=2'b00, in_ready=1. After deassert, no stale beat emerges within 10 cycles.
- Latency and streaming (same config, out_ready=1):
  - drive in=32'hFFFF_FFFF, then 32'hFFFF_FFFE, then 32'h7FFF_FFFF on consecutive cycles
  - z = 2'b11, 2'b10, 2'b01 on cycles 2, 3, 4 after the first accept, out_valid continuously high
- Backpressure (same config): hold out_ready=0 and push 3 beats -> in_ready falls after 2 accepts; z stable at first result. Release out_ready -> results drain in order with no loss or duplication.
- Padding and odd width (N=5, CH=1, REG_EVERY=1; L=2, S=2): in=5'b11111 -> z=1; in=5'b10111 -> z=0. Exhaustive over all 32 values must match the reference AND.
- INVERT and REG_EVERY sweep (N=64, CH=3, INVERT=1, REG_EVERY=2; L=3, S=2): all ones -> z=3'b000 after 2 cycles; clear bit 0 of channel 1 -> z=3'b010. Repeat with REG_EVERY=3 -> S=1, latency 1.
- Random handshake: random in_valid/out_ready (50%) over 10k beats, N=37, CH=4 -> scoreboard matches every beat in order; z stable while stalled.
